// File: rtl/detector.sv
// detector: HC-SR04 style trigger generator and echo pulse-width timer.
module detector #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ask_echo,
    input  logic        echo,
    output logic        valid,
    output logic        trig,
    output logic [15:0] echo_time
);
    typedef enum logic [1:0] {IDLE, TRIG, WAIT, MEASURE} state_t;
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t state, state_n;
    logic [2:0] ask_s, echo_s, warm;
    logic [15:0] cnt, cnt_n;
    logic fin, done, ask_rise, echo_rise;
    // warm keeps the zeroed synchronizers from faking a request edge right after reset
    assign ask_rise = warm[2] & ask_s[1] & ~ask_s[2];
    assign echo_rise = echo_s[1] & ~echo_s[2];
    always_ff @(posedge clk) begin
        if (rst) begin
            ask_s <= '0;
            echo_s <= '0;
            warm <= '0;
            state <= IDLE;
            cnt <= '0;
            fin <= 1'b0;
            trig <= 1'b0;
            valid <= 1'b0;
            echo_time <= '0;
        end else begin
            ask_s <= {ask_s[1:0], ask_echo};
            echo_s <= {echo_s[1:0], echo};
            warm <= {warm[1:0], 1'b1};
            state <= state_n;
            cnt <= cnt_n;
            fin <= done;
            trig <= (state == TRIG);
            valid <= fin | (valid & (state != TRIG));
            echo_time <= fin ? cnt : echo_time;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (ask_rise && !fin) begin
                    state_n = TRIG;
                    cnt_n = '0;
                end
            end
            TRIG: begin
                state_n = (cnt == TRIG_LAST) ? WAIT : TRIG;
                cnt_n = (cnt == TRIG_LAST) ? 16'd0 : cnt + 16'd1;
            end
            WAIT: begin
                if (echo_rise) begin
                    state_n = MEASURE;
                    cnt_n = 16'd1;
                end else if (cnt == WAIT_LAST) begin
                    state_n = IDLE;
                    cnt_n = 16'hFFFF;
                    done = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            MEASURE: begin
                if (!echo_s[1] || &cnt) begin
                    state_n = IDLE;
                    done = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_detector.sv
// tb_detector: directed stimulus for detector, checked every cycle against an
// edge-timestamp model plus hand-computed literal expectations.
module tb_detector;
    localparam int T = 10;
    localparam int TO = 300;
    localparam int HN = 131072;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ask_echo = 1'b1;
    logic echo = 1'b1;
    logic valid, trig;
    logic [15:0] echo_time;
    int n_pass = 0, n_total = 0;

    detector #(.TRIG_CYCLES(T), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ask_echo(ask_echo), .echo(echo),
        .valid(valid), .trig(trig), .echo_time(echo_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: input samples per edge; outputs derived from edge arithmetic.
    // A request edge sampled at edges c-3/c-2 is accepted at edge c; trig is high
    // after edges c+1..c+T; an echo edge acts no earlier than c+T+1; the result
    // appears one edge after the measurement ends.
    bit ah[HN];
    bit eh[HN];
    int cyc = 0;
    int acc, w, rel = 0, free_at = -10, pend_val;
    bit busy = 0, pend = 0, m_trig = 0, m_valid = 0, model_on = 0;
    logic [15:0] m_time = '0;

    initial forever begin
        int c;
        @(posedge clk);
        c = cyc;
        if (c < HN) begin
            ah[c] = ask_echo;
            eh[c] = echo;
        end
        if (rst) begin
            m_trig = 0; m_valid = 0; m_time = '0;
            busy = 0; pend = 0; rel = c + 1; free_at = c;
        end else begin
            if (pend) begin
                m_valid = 1; m_time = 16'(pend_val); pend = 0;
            end
            if (busy) begin
                if (c == acc + 1) m_valid = 0;
                m_trig = (c <= acc + T);
                if (c > acc + T) begin
                    if (w < 0) begin
                        if (eh[c-2] && !eh[c-3]) w = c;
                        else if (c == acc + T + TO) begin
                            busy = 0; pend = 1; pend_val = 65535; free_at = c + 1;
                        end
                    end else if (!eh[c-2] || c - w == 65535) begin
                        busy = 0; pend = 1; pend_val = c - w; free_at = c + 1;
                    end
                end
            end else if (c > free_at && c >= rel + 3 && ah[c-2] && !ah[c-3]) begin
                busy = 1; acc = c; w = -1;
            end
        end
        cyc++;
        model_on = 1;
    end

    int rises = 0, run = 0, last_len = 0, fall_cyc = 0, valid_cyc = 0;
    logic trig_q = 1'b0, valid_q = 1'b0;
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("trig_model", trig, m_trig);
            check("valid_model", valid, m_valid);
            check("time_model", echo_time, m_time);
        end
        if (trig && !trig_q) rises++;
        if (trig) run++;
        else if (trig_q) begin
            last_len = run; run = 0; fall_cyc = cyc;
        end
        if (valid && !valid_q) valid_cyc = cyc;
        trig_q = trig;
        valid_q = valid;
    end

    task automatic start_req(input string tag);
        ask_echo = 1;
        for (int i = 0; i < 20 && !trig; i++) @(negedge clk);
        check({tag, "_trig_on"}, trig, 1);
        check({tag, "_valid_drop"}, valid, 0);
        for (int i = 0; i < 40 && trig; i++) @(negedge clk);
        #1;
        check({tag, "_trig_len"}, last_len, T);
        ask_echo = 0;
    endtask

    task automatic run_meas(input string tag, input int gap, input int width,
                            input logic [15:0] prev, input bit poke);
        int r0;
        r0 = rises;
        check({tag, "_hold"}, echo_time, prev);
        start_req(tag);
        repeat (gap) @(negedge clk);
        echo = 1;
        for (int k = 0; k < width; k++) begin
            ask_echo = poke && k >= 5 && k < 9;
            @(negedge clk);
        end
        echo = 0;
        ask_echo = 0;
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        check({tag, "_valid"}, valid, 1);
        check({tag, "_time"}, echo_time, width);
        repeat (4) @(negedge clk);
        check({tag, "_one_trig"}, rises - r0, 1);
    endtask

    initial begin
        int widths[5] = '{1, 2, 4999, 5000, 37};
        int r;
        logic [15:0] prev;
        repeat (2) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_valid", valid, 0);
        check("rst_time", echo_time, 0);
        rst = 0;
        repeat (12) @(negedge clk);
        check("no_trig_after_rst", rises, 0);
        ask_echo = 0;
        echo = 0;
        repeat (4) @(negedge clk);

        run_meas("basic", 19, 100, 16'd0, 0);
        prev = 16'd100;
        foreach (widths[i]) begin
            run_meas($sformatf("b2b%0d", i), 3, widths[i], prev, 0);
            prev = 16'(widths[i]);
        end
        run_meas("ignored", 5, 60, prev, 1);

        start_req("timeout");
        for (int i = 0; i < TO + 20 && !valid; i++) @(negedge clk);
        #1;
        check("timeout_valid", valid, 1);
        check("timeout_time", echo_time, 16'hFFFF);
        check("timeout_delay", valid_cyc - fall_cyc, TO);
        repeat (4) @(negedge clk);

        start_req("sat");
        repeat (5) @(negedge clk);
        echo = 1;
        r = cyc;
        for (int i = 0; i < 70000 && !valid; i++) @(negedge clk);
        #1;
        check("sat_valid", valid, 1);
        check("sat_time", echo_time, 16'hFFFF);
        check("sat_latency", valid_cyc - r, 65539);
        repeat (10) @(negedge clk);
        echo = 0;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/detector.md
# detector

Ultrasonic range-sensor front end for an HC-SR04-style transducer. A rising edge on `ask_echo` starts one measurement: the block emits a fixed-width trigger pulse on `trig`, then times the sensor's `echo` pulse in clock cycles. It presents the result on `echo_time`, qualified by `valid`. It sits between the sensor pins and the host logic that requests and consumes distance samples.

## Interface
Parameters:
- `TRIG_CYCLES`, default 10: width of the `trig` pulse in `clk` cycles, minimum 1.
- `TIMEOUT_CYCLES`, default 65535: maximum number of cycles to wait for an `echo` rising edge after `trig` ends.

Ports:
- `clk`  input  1: single clock; every register is updated on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `ask_echo`  input  1: measurement request, asynchronous to `clk`; only its rising edge is significant.
- `echo`  input  1: sensor echo pulse, asynchronous to `clk`.
- `valid`  output  1: level signal; high means `echo_time` holds a completed result.
- `trig`  output  1: registered trigger pulse to the sensor.
- `echo_time`  output  16: measured `echo` high time in `clk` cycles; unsigned, saturating.

## Operation
- Synchronizers:
  - `ask_echo` and `echo` each pass through a 2-flop synchronizer before any use.
  - A third register per input provides rising-edge detection.
- State machine states: IDLE, TRIG, WAIT, MEASURE.
- IDLE:
  - A synchronized `ask_echo` rising edge moves to TRIG.
  - On that same edge: `valid` clears to 0 and the trigger counter is loaded.
- TRIG:
  - `trig` is 1 for exactly `TRIG_CYCLES` cycles, then the state moves to WAIT.
  - The timeout counter is cleared on entry to WAIT.
- WAIT:
  - A synchronized `echo` rising edge moves to MEASURE with the count set to 1.
  - If `echo` is already high on entry to WAIT, the block waits for it to fall and then rise again.
  - If `TIMEOUT_CYCLES` cycles elapse with no rising edge: `echo_time` = 16'hFFFF, `valid` = 1, back to IDLE.
- MEASURE:
  - The count increments by 1 on each cycle that synchronized `echo` stays 1.
  - The count saturates at 16'hFFFF and does not wrap.
  - On the first cycle synchronized `echo` is 0: `echo_time` takes the count, `valid` = 1, back to IDLE.
  - If the count reaches 16'hFFFF while `echo` is still high: finish immediately with `echo_time` = 16'hFFFF and `valid` = 1.
- Result: a synchronized `echo` pulse of W cycles gives `echo_time` = W (1 ≤ W ≤ 65535).
- Requests while busy: `ask_echo` edges in TRIG, WAIT or MEASURE are ignored. They are not queued.
- Output hold: `echo_time` and `valid` keep their values until the next accepted request, which clears `valid` only. `echo_time` keeps its old value until overwritten.

## Timing
- Reset values: `trig` = 0, `valid` = 0, `echo_time` = 0, state = IDLE, all synchronizer and counter registers = 0.
- Reset during any state returns to IDLE on the next edge; any measurement in progress is abandoned.
- Request latency: if `ask_echo` is first sampled high at edge N, `trig` is 1 after edge N+3 and stays 1 for `TRIG_CYCLES` edges.
- `valid` falls on the same edge that `trig` rises.
- Echo latency: the end of `echo` is seen 3 edges after the input falls; `valid` and `echo_time` update on the following edge.
- Simultaneous `ask_echo` rising edge and `valid` going high: the result is written and the request is ignored. Another request is accepted only from IDLE on a later edge.
- All outputs are driven directly from registers, with no combinational paths from inputs.

## Test plan
- Reset: assert `rst` for 2 cycles with `ask_echo` = 1 and `echo` = 1 -> `trig` = 0, `valid` = 0, `echo_time` = 0, and no `trig` after release until `ask_echo` goes 0 and then 1.
- Basic measurement: `ask_echo` 0→1, then `echo` high for 100 cycles starting 20 cycles after `trig` falls -> `trig` high for exactly 10 cycles, then `valid` = 1 with `echo_time` = 100.
- Back-to-back requests: five sequential requests with random echo widths of 1–5000 cycles -> each result equals its width, `valid` drops at each new `trig`, and `echo_time` holds between requests.
- Ignored request: pulse `ask_echo` during MEASURE -> no extra `trig`, and the result is unaffected.
- Timeout: a request with `echo` held low -> `valid` = 1 and `echo_time` = 16'hFFFF exactly `TIMEOUT_CYCLES` cycles after `trig` falls.
- Saturation: `echo` held high for 70000 cycles -> `echo_time` = 16'hFFFF and `valid` = 1 without waiting for `echo` to fall.
